freq_shift: RTL and testbench



---
 rtl/freq_shift.sv | 110 +++++++++++
 tb/tb_freq_shift.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_shift.sv
// freq_shift: complex mixer that multiplies an IQ stream by sig_gen's cos/sin (up-shift, or conjugate down-shift with FREQ_SHIFT_CONJ_EN).
// Latency 3 clk fire-to-valid, 1 sample/clk; an output stall freezes every stage and both input readies drop.
module freq_shift #(
  parameter int N_BITS   = 8,
  parameter int OUT_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [N_BITS-1:0]   i_in,
  input  logic signed [N_BITS-1:0]   q_in,
  input  logic                       s_axis_iq_tvalid,
  output logic                       s_axis_iq_tready,
  input  logic signed [N_BITS-1:0]   cosine,
  input  logic signed [N_BITS-1:0]   sine,
  input  logic                       nco_tvalid,
  output logic                       nco_tready,
  output logic signed [OUT_BITS-1:0] i_out,
  output logic signed [OUT_BITS-1:0] q_out,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
);

  localparam int PW = 2 * N_BITS;
  localparam int SW = PW + 1;
  localparam int RW = PW + 2;

  localparam logic signed [RW-1:0] RND  = RW'(1) <<< (N_BITS - 2);
  localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (OUT_BITS - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic en;
  logic fire;

  logic signed [PW-1:0] p_ic, p_qs, p_is, p_qc;
  logic                 v1;
  logic signed [SW-1:0] s_i, s_q;
  logic                 v2;
  logic signed [OUT_BITS-1:0] r_i, r_q;

  // en is held low in reset so the readies are already 0 during reset
  assign en               = !reset && (!m_axis_tvalid || m_axis_tready);
  assign s_axis_iq_tready = en && nco_tvalid;
  assign nco_tready       = en && s_axis_iq_tvalid;
  assign fire             = en && s_axis_iq_tvalid && nco_tvalid;

  function automatic logic signed [OUT_BITS-1:0] rnd_sat(input logic signed [SW-1:0] s);
    logic signed [RW-1:0] r;
    r = (RW'(s) + RND) >>> (N_BITS - 1);
    if (r > MAXV)
      return MAXV[OUT_BITS-1:0];
    else if (r < MINV)
      return MINV[OUT_BITS-1:0];
    else
      return r[OUT_BITS-1:0];
  endfunction

  always_comb begin
    r_i = rnd_sat(s_i);
    r_q = rnd_sat(s_q);
  end

  // stage 1: four products
  always_ff @(posedge clk) begin
    if (reset) begin
      p_ic <= '0;
      p_qs <= '0;
      p_is <= '0;
      p_qc <= '0;
      v1   <= 1'b0;
    end else if (en) begin
      p_ic <= PW'(i_in) * PW'(cosine);
      p_qs <= PW'(q_in) * PW'(sine);
      p_is <= PW'(i_in) * PW'(sine);
      p_qc <= PW'(q_in) * PW'(cosine);
      v1   <= fire;
    end
  end

  // stage 2: complex combine; the conjugate build mixes by e^{-jwn}
  always_ff @(posedge clk) begin
    if (reset) begin
      s_i <= '0;
      s_q <= '0;
      v2  <= 1'b0;
    end else if (en) begin
`ifdef FREQ_SHIFT_CONJ_EN
      s_i <= SW'(p_ic) + SW'(p_qs);
      s_q <= SW'(p_qc) - SW'(p_is);
`else
      s_i <= SW'(p_ic) - SW'(p_qs);
      s_q <= SW'(p_is) + SW'(p_qc);
`endif
      v2  <= v1;
    end
  end

  // stage 3: round half up, saturate, present
  always_ff @(posedge clk) begin
    if (reset) begin
      i_out         <= '0;
      q_out         <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (en) begin
      i_out         <= r_i;
      q_out         <= r_q;
      m_axis_tvalid <= v2;
    end
  end

endmodule

// File: tb/tb_freq_shift.sv
// Bench for freq_shift: directed cases plus randomized traffic, scoreboard-checked against an arithmetic reference.
module tb_freq_shift;
  localparam int N = 8;
  localparam int O = 8;

  logic clk = 1'b0;
  logic reset;
  logic signed [N-1:0] i_in, q_in, cosine, sine;
  logic s_axis_iq_tvalid, s_axis_iq_tready;
  logic nco_tvalid, nco_tready;
  logic signed [O-1:0] i_out, q_out;
  logic m_axis_tvalid, m_axis_tready;

  freq_shift #(.N_BITS(N), .OUT_BITS(O)) dut (
    .clk(clk), .reset(reset),
    .i_in(i_in), .q_in(q_in), .s_axis_iq_tvalid(s_axis_iq_tvalid), .s_axis_iq_tready(s_axis_iq_tready),
    .cosine(cosine), .sine(sine), .nco_tvalid(nco_tvalid), .nco_tready(nco_tready),
    .i_out(i_out), .q_out(q_out), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct { int ei; int eq; int fcyc; bit seen; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_check = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact complex product, scaled by 2^-(N-1) with round-half-up, then clipped
  function automatic int scale(input int s);
    int r;
    int hi;
    int lo;
    r  = (s + (1 << (N - 2))) >>> (N - 1);
    hi = (1 << (O - 1)) - 1;
    lo = -(1 << (O - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

  task automatic model(input int i, input int q, input int c, input int s, output int ei, output int eq);
`ifdef FREQ_SHIFT_CONJ_EN
    ei = scale(i * c + q * s);
    eq = scale(q * c - i * s);
`else
    ei = scale(i * c - q * s);
    eq = scale(i * s + q * c);
`endif
  endtask

  // One clock of stimulus: drive at negedge, sample handshakes just before the next posedge
  task automatic cycle(input bit iv, input bit nv, input int i, input int q, input int c, input int s,
                       input bit rdy, input bit rst, output bit fired);
    exp_t e;
    bit en_exp;
    @(negedge clk);
    reset = rst;
    s_axis_iq_tvalid = iv;
    nco_tvalid = nv;
    i_in = N'(i);
    q_in = N'(q);
    cosine = N'(c);
    sine = N'(s);
    m_axis_tready = rdy;
    #4;
    fired = 1'b0;
    if (rst) begin
      sb.delete();
      check("iq_rdy_in_reset", int'(s_axis_iq_tready), 0);
      check("nco_rdy_in_reset", int'(nco_tready), 0);
    end else begin
      en_exp = !m_axis_tvalid || rdy;
      check("iq_rdy", int'(s_axis_iq_tready), int'(en_exp && nv));
      check("nco_rdy", int'(nco_tready), int'(en_exp && iv));
      if (iv && nv && s_axis_iq_tready && nco_tready) begin
        fired = 1'b1;
        model(i, q, c, s, e.ei, e.eq);
        e.fcyc = cyc;
        e.seen = 1'b0;
        sb.push_back(e);
      end
    end
  endtask

  // Monitor: any presented output must match the head of the scoreboard, held or not
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset && m_axis_tvalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got i=%0d q=%0d, expected no output", i_out, q_out);
        end else begin
          check("i_out", int'(i_out), sb[0].ei);
          check("q_out", int'(q_out), sb[0].eq);
          if (lat_check && !sb[0].seen)
            check("latency", cyc - sb[0].fcyc, 3);
          sb[0].seen = 1'b1;
          if (m_axis_tready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    bit f;
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, f);
  endtask

  task automatic send(input int i, input int q, input int c, input int s);
    bit f;
    cycle(1'b1, 1'b1, i, q, c, s, 1'b1, 1'b0, f);
    check("send_fired", int'(f), 1);
  endtask

  function automatic int rnd_val();
    if ($urandom_range(0, 7) == 0) return -(1 << (N - 1));
    return int'($urandom_range(0, (1 << N) - 1)) - (1 << (N - 1));
  endfunction

  initial begin
    bit f;
    int idx;
    int guard;
    int ai[6];
    int aq[6];
    reset = 1'b1;
    {s_axis_iq_tvalid, nco_tvalid, m_axis_tready} = '0;
    {i_in, q_in, cosine, sine} = '0;

    // Reset state
    cycle(1'b1, 1'b1, 5, 5, 5, 5, 1'b1, 1'b1, f);
    cycle(1'b1, 1'b1, 5, 5, 5, 5, 1'b1, 1'b1, f);
    @(posedge clk); #1;
    check("rst_tvalid", int'(m_axis_tvalid), 0);
    check("rst_i_out", int'(i_out), 0);
    check("rst_q_out", int'(q_out), 0);

    // Directed values with exact latency
    lat_check = 1'b1;
    send(64, 0, 127, 0);
    idle(5);
    send(0, 64, 0, 127);
    idle(5);
    send(-128, -128, -128, 127);
    idle(5);
    send(-128, -128, -128, -128);
    send(127, -128, -128, 127);
    idle(5);

    // Unmatched IQ valid waits; no fire while NCO is invalid
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0, 10, 20, 100, -50, 1'b1, 1'b0, f);
      check("no_fire_without_nco", int'(f), 0);
    end
    cycle(1'b1, 1'b1, 10, 20, 100, -50, 1'b1, 1'b0, f);
    check("fire_after_nco", int'(f), 1);
    idle(5);
    lat_check = 1'b0;

    // Six samples with a 4-clk downstream stall starting in cycle 2
    for (int k = 0; k < 6; k++) begin
      ai[k] = rnd_val();
      aq[k] = rnd_val();
    end
    idx = 0;
    guard = 0;
    while (idx < 6 && guard < 40) begin
      cycle(1'b1, 1'b1, ai[idx], aq[idx], 90, -70, !(guard >= 2 && guard < 6), 1'b0, f);
      if (f) idx++;
      guard++;
    end
    check("stall_all_sent", idx, 6);
    idle(8);
    check("stall_drained", sb.size(), 0);

    // Reset with two samples in flight
    send(50, -30, 100, 20);
    send(-40, 60, -90, 110);
    cycle(1'b1, 1'b1, 1, 2, 3, 4, 1'b1, 1'b1, f);
    @(posedge clk); #1;
    check("mid_rst_tvalid", int'(m_axis_tvalid), 0);
    check("mid_rst_i_out", int'(i_out), 0);
    check("mid_rst_q_out", int'(q_out), 0);
    idle(6);
    lat_check = 1'b1;
    send(33, -77, 120, 45);
    idle(5);
    lat_check = 1'b0;

    // Randomized traffic with random valids and backpressure
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, rnd_val(), rnd_val(), rnd_val(), rnd_val(),
            $urandom_range(0, 3) != 0, 1'b0, f);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      idle(1);
      guard++;
    end
    check("final_drain", sb.size(), 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
